// File: rtl/pe_pkg.sv
// Shared definitions for the modular PE array: per-beat op encodings and pipeline depth.
// No logic here; imported by pe_lane and pe_array_stream.
package pe_pkg;

   typedef enum logic [1:0] {
      PE_ADD    = 2'b00,
      PE_SUB    = 2'b01,
      PE_MUL    = 2'b10,
      PE_MULADD = 2'b11
   } pe_mode_e;

   localparam int LATENCY = 4;

endpackage

// File: rtl/pe_lane.sv
// One modular-arithmetic lane: operand regs, op/product, Barrett quotient, correction+output.
// Four register stages, all gated by the shared advance enable so a stall freezes the lane.
module pe_lane
   import pe_pkg::*;
#(
   parameter int W = 54
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         adv_i,
   input  pe_mode_e     mode_i,
   input  logic         lane_en_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   input  logic [W-1:0] q_i,
   input  logic [W:0]   mu_i,
   output logic [W-1:0] res_o
);

   logic [W-1:0]   a_q, b_q, c_q;
   logic [2*W-1:0] ae, be, ce, qe;
   logic [2*W-1:0] x_d, x_q;
   logic [2*W+1:0] qm;
   logic [W:0]     qhat_d, qhat_q;
   logic [W+1:0]   xl_q;
   logic [W+1:0]   qw, qq, r0, r1, r2;
   logic [W-1:0]   res_d, res_q;
   logic           unused_bits;

   assign ae = {{W{1'b0}}, a_q};
   assign be = {{W{1'b0}}, b_q};
   assign ce = {{W{1'b0}}, c_q};
   assign qe = {{W{1'b0}}, q_i};

   // Every mode is funnelled into one value x < q^2 so a single Barrett path reduces all of them.
   always_comb begin
      x_d = '0;
      case (mode_i)
         PE_ADD:  x_d = ae + be;
         PE_SUB:  x_d = ae + qe - be;
         PE_MUL:  x_d = ae * be;
         default: x_d = ae * be + ce;
      endcase
   end

   assign qm     = {{(W+1){1'b0}}, x_q[2*W-1:W-1]} * {{(W+1){1'b0}}, mu_i};
   assign qhat_d = qm[2*W+1:W+1];

   // Remainder after the estimate is below 3q, so only W+2 bits and two corrections are needed.
   assign qw    = {2'b00, q_i};
   assign qq    = {1'b0, qhat_q} * qw;
   assign r0    = xl_q - qq;
   assign r1    = (r0 >= qw) ? r0 - qw : r0;
   assign r2    = (r1 >= qw) ? r1 - qw : r1;
   assign res_d = lane_en_i ? r2[W-1:0] : '0;

   assign unused_bits = ^{qm[W:0], r2[W+1:W]};

   always_ff @(posedge clk_i) begin
      if (adv_i) begin
         a_q    <= a_i;
         b_q    <= b_i;
         c_q    <= c_i;
         x_q    <= x_d;
         qhat_q <= qhat_d;
         xl_q   <= x_q[W+1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         res_q <= '0;
      end else if (adv_i) begin
         res_q <= res_d;
      end
   end

   assign res_o = res_q;

endmodule

// File: rtl/pe_array_stream.sv
// LANES-wide modular PE array, fixed LATENCY; any output stall freezes the whole pipe and drops in_ready.
// Defining PE_ARRAY_PERF_CNT_EN adds the beat_cnt/stall_cnt outputs.
module pe_array_stream
   import pe_pkg::*;
#(
   parameter int LANES      = 256,
   parameter int DATA_WIDTH = 54
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [1:0]                  in_mode,
   input  logic [LANES-1:0]            in_lane_en,
   input  logic [DATA_WIDTH-1:0]       modulus,
   input  logic [DATA_WIDTH:0]         modulus_inv,
   input  logic [DATA_WIDTH*LANES-1:0] in_a,
   input  logic [DATA_WIDTH*LANES-1:0] in_b,
   input  logic [DATA_WIDTH*LANES-1:0] in_c,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH*LANES-1:0] out_data,
   output logic                        busy
`ifdef PE_ARRAY_PERF_CNT_EN
   ,
   output logic [31:0]                 beat_cnt,
   output logic [31:0]                 stall_cnt
`endif
);

   localparam int W = DATA_WIDTH;

   logic               adv;
   logic [LATENCY-1:0] vld_d, vld_q;
   pe_mode_e           mode_q;
   logic [LANES-1:0]   en1_q, en2_q, en3_q;

   assign out_valid = vld_q[LATENCY-1];
   assign adv       = !(out_valid && !out_ready);
   assign in_ready  = adv;
   assign busy      = |vld_q;
   assign vld_d     = {vld_q[LATENCY-2:0], in_valid};

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else if (adv) begin
         vld_q <= vld_d;
      end
   end

   // Mode is consumed in stage 2 and lane enable at the output register, so each travels only that far.
   always_ff @(posedge clk) begin
      if (adv) begin
         mode_q <= pe_mode_e'(in_mode);
         en1_q  <= in_lane_en;
         en2_q  <= en1_q;
         en3_q  <= en2_q;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      pe_lane #(.W(W)) u_lane (
         .clk_i     (clk),
         .rst_i     (rst),
         .adv_i     (adv),
         .mode_i    (mode_q),
         .lane_en_i (en3_q[i]),
         .a_i       (in_a[i*W +: W]),
         .b_i       (in_b[i*W +: W]),
         .c_i       (in_c[i*W +: W]),
         .q_i       (modulus),
         .mu_i      (modulus_inv),
         .res_o     (out_data[i*W +: W])
      );
   end

`ifdef PE_ARRAY_PERF_CNT_EN
   logic [31:0] beat_cnt_q, stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (out_valid && out_ready) beat_cnt_q <= beat_cnt_q + 32'd1;
         if (out_valid && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign beat_cnt  = beat_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   // Counters compiled out: the streaming handshake is the entire interface.
`endif

endmodule

// File: tb/tb_pe_array_stream.sv
// Directed + randomized bench for pe_array_stream (W=8, LANES=4) with an arithmetic reference model.
module tb_pe_array_stream;
   import pe_pkg::*;

   localparam int W = 8;
   localparam int L = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid, in_ready, out_valid, out_ready, busy;
   logic [1:0]     in_mode;
   logic [L-1:0]   in_lane_en;
   logic [W-1:0]   modulus;
   logic [W:0]     modulus_inv;
   logic [W*L-1:0] in_a, in_b, in_c, out_data;
`ifdef PE_ARRAY_PERF_CNT_EN
   logic [31:0]    beat_cnt, stall_cnt;
`endif

   int checks = 0;
   int failures = 0;
   int out_cnt = 0;
   logic [W*L-1:0] expq[$];
   logic           prev_stall = 1'b0;
   logic [W*L-1:0] prev_data = '0;

   always #5 clk = ~clk;

   pe_array_stream #(.LANES(L), .DATA_WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_mode     (in_mode),
      .in_lane_en  (in_lane_en),
      .modulus     (modulus),
      .modulus_inv (modulus_inv),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_c        (in_c),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy)
`ifdef PE_ARRAY_PERF_CNT_EN
      ,
      .beat_cnt    (beat_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W*L-1:0] model(input logic [1:0] m, input logic [L-1:0] en,
                                            input logic [W*L-1:0] a, input logic [W*L-1:0] b,
                                            input logic [W*L-1:0] c, input longint q);
      logic [W*L-1:0] r;
      longint av, bv, cv, x;
      r = '0;
      for (int i = 0; i < L; i++) begin
         av = longint'(a[i*W +: W]);
         bv = longint'(b[i*W +: W]);
         cv = longint'(c[i*W +: W]);
         case (m)
            2'd0:    x = av + bv;
            2'd1:    x = av - bv + q;
            2'd2:    x = av * bv;
            default: x = av * bv + cv;
         endcase
         if (en[i]) r[i*W +: W] = W'(x % q);
      end
      return r;
   endfunction

   function automatic logic [W*L-1:0] rep(input int v);
      logic [W*L-1:0] r;
      logic [W-1:0]   vv;
      vv = v[W-1:0];
      for (int i = 0; i < L; i++) r[i*W +: W] = vv;
      return r;
   endfunction

   function automatic logic [W*L-1:0] rand_vec(input int q);
      logic [W*L-1:0] r;
      for (int i = 0; i < L; i++) r[i*W +: W] = W'($urandom_range(q - 1));
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_beat();
      in_mode    = 2'($urandom_range(3));
      in_lane_en = L'($urandom);
      in_a       = rand_vec(int'(modulus));
      in_b       = rand_vec(int'(modulus));
      in_c       = rand_vec(int'(modulus));
   endtask

   task automatic send_one();
      int n = 0;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", in_ready, 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      check("out_timeout", out_valid, 1);
   endtask

   // Scoreboard: expectations are pushed at acceptance and popped at every output transfer.
   always @(negedge clk) begin
      if (rst) begin
         expq.delete();
         out_cnt    = 0;
         prev_stall = 1'b0;
      end else begin
         check("in_ready_rule", in_ready, !(out_valid && !out_ready));
         if (prev_stall) check("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               check("spurious_out", out_valid, 0);
            end else begin
               check("out_data", out_data, expq.pop_front());
               out_cnt++;
            end
         end
         if (in_valid && in_ready)
            expq.push_back(model(in_mode, in_lane_en, in_a, in_b, in_c, longint'(modulus)));
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   initial begin
      int lat;
      int seen;
      int acc;
      int cyc;
      int exp_sweep[4] = '{2, 4, 91, 191};
      logic [13:0] pat, exp_pat;
      logic [W*L-1:0] b2b_a;

      rst = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_lane_en = '1;
      in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b1;
      modulus = 8'd251; modulus_inv = 9'd261;
      step();
      step();
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
      step();
      rst = 1'b0;

      // Single beats per mode with fixed operands and hand-derived results.
      for (int m = 0; m < 4; m++) begin
         in_mode    = 2'(m);
         in_lane_en = '1;
         in_a = rep(m == 1 ? 3 : (m >= 2 ? 200 : 250));
         in_b = rep(m == 1 ? 250 : (m >= 2 ? 200 : 3));
         in_c = rep(100);
         send_one();
         wait_out(lat);
         check("sweep_latency", lat, LATENCY);
         check("sweep_result", out_data, rep(exp_sweep[m]));
         step();
      end

      // Back-to-back burst of 8 beats cycling modes: output must be a contiguous run.
      pat = '0;
      for (int k = 0; k < 14; k++) begin
         exp_pat[k] = (k >= LATENCY) && (k < 8 + LATENCY);
         in_valid = (k < 8);
         if (k < 8) begin
            rand_beat();
            in_mode = 2'(k % 4);
         end
         @(negedge clk);
         pat[k] = out_valid;
         step();
      end
      check("b2b_pattern", pat, exp_pat);
      b2b_a = in_a;

      // Fill pipeline, stall for 5 cycles, release and drain.
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rand_beat();
         in_valid = 1'b1;
         step();
      end
      out_ready = 1'b0;
      rand_beat();
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      repeat (10) step();
      @(negedge clk);
      check("drain_busy", busy, 0);
      check("drain_queue", expq.size(), 0);
`ifdef PE_ARRAY_PERF_CNT_EN
      check("stall_cnt", stall_cnt, 5);
      check("beat_cnt", beat_cnt, out_cnt);
`endif
      step();

      // Lane enable mask: only lanes 0 and 2 carry results.
      in_mode = 2'd2; in_lane_en = 4'b0101;
      in_a = rep(200); in_b = rep(200); in_c = b2b_a;
      send_one();
      wait_out(lat);
      check("lane_en_result", out_data, 32'h005B005B);
      step();

      // Reset with 3 beats in flight: nothing may emerge afterwards.
      in_lane_en = '1;
      for (int k = 0; k < 3; k++) begin
         rand_beat();
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("busy_inflight", busy, 1);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 1);
`ifdef PE_ARRAY_PERF_CNT_EN
      check("midrst_beat_cnt", beat_cnt, 0);
`endif
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midrst_late_out", seen, 0);
      step();

      // Randomized traffic with random backpressure over several moduli.
      for (int ph = 0; ph < 10; ph++) begin
         in_valid  = 1'b0;
         out_ready = 1'b1;
         cyc = 0;
         while (busy && cyc < 50) begin
            step();
            cyc++;
         end
         check("idle_before_q", busy, 0);
         if (ph > 0) begin
            modulus     = 8'($urandom_range(129, 255));
            modulus_inv = 9'(65536 / int'(modulus));
         end
         acc = 0;
         cyc = 0;
         rand_beat();
         while (acc < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(9) < 8);
            out_ready = ($urandom_range(9) < 7);
            @(negedge clk);
            if (in_valid && in_ready) begin
               acc++;
               step();
               rand_beat();
            end else begin
               step();
            end
            cyc++;
         end
         check("random_progress", acc, 1000);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (12) step();
      @(negedge clk);
      check("final_queue", expq.size(), 0);
      check("final_busy", busy, 0);
`ifdef PE_ARRAY_PERF_CNT_EN
      check("final_beat_cnt", beat_cnt, out_cnt);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
